// File: rtl/keyio_pkg.sv
// Shared types and helpers for the key-matrix scanner and its event queue.
package keyio_pkg;

   typedef struct packed {
      logic       press;
      logic [3:0] code;
   } key_event_t;

   localparam int EVT_PRESS_BIT = 7;

   function automatic logic [15:0] pack_event(key_event_t evt);
      logic [15:0] word;
      word                = 16'h0000;
      word[EVT_PRESS_BIT] = evt.press;
      word[3:0]           = evt.code;
      return word;
   endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word fall-through event queue. A push on a full queue is accepted only
// when a pop frees the head slot in the same cycle.
module key_fifo
   import keyio_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  key_event_t din,
   input  logic       pop,
   output key_event_t dout,
   output logic       empty,
   output logic       full
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   key_event_t  mem_q [DEPTH];
   logic        wr_ok;
   logic        rd_ok;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign rd_ok = pop && !empty;
   assign wr_ok = push && (!full || rd_ok);
   assign dout  = mem_q[rptr_q[AW-1:0]];

   // Pointer advance; the extra MSB distinguishes full from empty.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (wr_ok) wptr_d = wptr_q + (AW+1)'(1);
      if (rd_ok) rptr_d = rptr_q + (AW+1)'(1);
   end

   // Pointer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage needs no reset: the head is only visible while non-empty.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/keyscan.sv
// Key-matrix scanner: drives one column per slot, latches the rows at the end
// of the slot, debounces them one row per cycle in the following slot and
// queues press/release events for the core.
module keyscan
   import keyio_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int SCAN_DIV   = 10,
   parameter int DEBOUNCE   = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [ROWS-1:0] row_in,
   output logic [COLS-1:0] col_drv,
   input  logic            rd_en,
   output logic            key_valid,
   output logic [15:0]     rd_dat,
   output logic [15:0]     key_state,
   output logic            overflow,
   input  logic            clr_ovf
);

   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   logic [SCAN_DIV-1:0] div_q, div_d;
   logic [CW-1:0]       col_q, col_d;
   logic [CW-1:0]       scol_q, scol_d;
   logic [ROWS-1:0]     samp_q, samp_d;
   logic [15:0]         ks_q, ks_d;
   logic [1:0]          cnt_q [16];
   logic [1:0]          cnt_d [16];
   logic                ovf_q, ovf_d;

   logic                evt_vld;
   key_event_t          evt;
   key_event_t          head;
   logic                fifo_empty;
   logic                fifo_full;
   logic                pop;
   logic [3:0]          code;
   logic [ROWS-1:0]     row_sh;
   logic                smp;

   assign pop       = rd_en && !fifo_empty;
   assign key_valid = !fifo_empty;
   assign rd_dat    = key_valid ? pack_event(head) : 16'h0000;
   assign key_state = ks_q;
   assign overflow  = ovf_q;

   // Free-running divider; at the end of each slot latch the rows and move on.
   always_comb begin
      div_d  = div_q + SCAN_DIV'(1);
      col_d  = col_q;
      scol_d = scol_q;
      samp_d = samp_q;
      if (&div_q) begin
         samp_d = row_in;
         scol_d = col_q;
         col_d  = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
      end
   end

   // One-hot column drive follows the registered column index.
   always_comb begin
      col_drv        = '0;
      col_drv[col_q] = 1'b1;
   end

   // Debounce one row of the latched column per cycle, at most one event.
   always_comb begin
      ks_d    = ks_q;
      cnt_d   = cnt_q;
      evt_vld = 1'b0;
      evt     = '0;
      code    = 4'(int'(scol_q) * ROWS + int'(div_q));
      row_sh  = samp_q >> div_q;
      smp     = row_sh[0];
      if (int'(div_q) < ROWS) begin
         if (smp == ks_q[code]) begin
            cnt_d[code] = 2'd0;
         end else if (cnt_q[code] == 2'(DEBOUNCE - 1)) begin
            ks_d[code]  = smp;
            cnt_d[code] = 2'd0;
            evt_vld     = 1'b1;
            evt.press   = smp;
            evt.code    = code;
         end else begin
            cnt_d[code] = cnt_q[code] + 2'd1;
         end
      end
   end

   // Sticky overflow: a drop in the same cycle as a clear wins.
   always_comb begin
      ovf_d = ovf_q;
      if (evt_vld && fifo_full && !pop) ovf_d = 1'b1;
      else if (clr_ovf)                 ovf_d = 1'b0;
   end

   // Scanner, debounce and overflow state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q  <= '0;
         col_q  <= '0;
         scol_q <= '0;
         samp_q <= '0;
         ks_q   <= '0;
         ovf_q  <= 1'b0;
         for (int i = 0; i < 16; i++) cnt_q[i] <= 2'd0;
      end else begin
         div_q  <= div_d;
         col_q  <= col_d;
         scol_q <= scol_d;
         samp_q <= samp_d;
         ks_q   <= ks_d;
         ovf_q  <= ovf_d;
         cnt_q  <= cnt_d;
      end
   end

   key_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (evt_vld),
      .din  (evt),
      .pop  (pop),
      .dout (head),
      .empty(fifo_empty),
      .full (fifo_full)
   );

endmodule
